// File: rtl/byte_tx_serializer_pkg.sv
// tx_pkg: shared types and constants for the byte transmitter.
//   tx_state_t : frame state machine encoding. PARITY is always present in
//                the enum; it is only reachable when TX_PARITY_EN is defined.
//   LINE_IDLE / LINE_START : serial line levels.
//   DATA_BITS  : payload bits per frame.
package tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam int   DATA_BITS  = 8;

endpackage

// File: rtl/byte_tx_serializer_bit_timer.sv
// tx_bit_timer: serial bit-period divider.
//   CLK   in  clock, rising edge
//   RST   in  asynchronous active-high reset
//   clear in  restart the period at 0 on the next cycle (state entry)
//   tick  out high on the last cycle of each BIT_DIV-cycle bit period
// With BIT_DIV=1 every cycle is a tick and no counter exists.
module tx_bit_timer #(
  parameter int BIT_DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic tick
);

  localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  generate
    if (BIT_DIV == 1) begin : g_const
      logic unused_clear;
      assign unused_clear = clear;
      assign tick = 1'b1;
    end else begin : g_cnt
      logic [CW-1:0] cnt_q, cnt_d;

      assign tick = (cnt_q == CW'(BIT_DIV - 1));

      // Wrapping on tick keeps consecutive DATA bits aligned without a clear.
      always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) cnt_d = '0;
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end
    end
  endgenerate

endmodule

// File: rtl/byte_tx_serializer.sv
// byte_tx_serializer: accepts a byte on a valid/ready handshake and shifts it
// out as start bit, 8 data bits LSB-first, [parity], stop bit.
//   CLK      in  clock, rising edge
//   RST      in  asynchronous active-high reset
//   IN_VALID in  source presents a word on IN_DATA
//   IN_DATA  in  word to transmit
//   IN_READY out high exactly while IDLE
//   TX_OUT   out registered serial line, idles high
//   BUSY     out frame in progress (any state but IDLE)
//   DONE     out one-cycle pulse in the first IDLE cycle after a frame
// Optional build macro TX_PARITY_EN: adds an even-parity bit after the data.
module byte_tx_serializer
  import tx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int BIT_DIV = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              IN_READY,
  output logic              TX_OUT,
  output logic              BUSY,
  output logic              DONE
);

  localparam int IW = $clog2(DATA_BITS);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              tick, accept, bit_shift;
`ifdef TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign accept    = IN_VALID && (state_q == IDLE);
  assign bit_shift = (state_q == DATA) && tick;

  // Every state change restarts the bit period.
  tx_bit_timer #(.BIT_DIV(BIT_DIV)) u_timer (
    .CLK  (CLK),
    .RST  (RST),
    .clear(state_d != state_q),
    .tick (tick)
  );

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      tx_q    <= LINE_IDLE;
      done_q  <= 1'b0;
`ifdef TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = START;
      START:  if (tick)   state_d = DATA;
      DATA:   if (tick && (idx_q == IW'(DATA_BITS - 1))) begin
`ifdef TX_PARITY_EN
                state_d = PARITY;
`else
                state_d = STOP;
`endif
              end
      PARITY: if (tick)   state_d = STOP;
      STOP:   if (tick)   state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  // Outputs and datapath next values. TX level is derived from the state
  // being entered so the registered line changes on the same edge as state.
  always_comb begin
    IN_READY = (state_q == IDLE);
    BUSY     = (state_q != IDLE);
    DONE     = done_q;
    TX_OUT   = tx_q;

    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (accept) begin
      shreg_d = IN_DATA;
      idx_d   = '0;
    end else if (bit_shift) begin
      shreg_d = shreg_q >> 1;
      idx_d   = idx_q + 1'b1;
    end

`ifdef TX_PARITY_EN
    par_d = accept ? ^IN_DATA : par_q;
`endif

    done_d = (state_q == STOP) && tick;

    tx_d = LINE_IDLE;
    unique case (state_d)
      IDLE:   tx_d = LINE_IDLE;
      START:  tx_d = LINE_START;
      DATA:   tx_d = shreg_d[0];
`ifdef TX_PARITY_EN
      PARITY: tx_d = par_d;
`else
      PARITY: tx_d = LINE_IDLE;
`endif
      STOP:   tx_d = LINE_IDLE;
      default: tx_d = LINE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_byte_tx_serializer.sv
// Bench for byte_tx_serializer: two instances (BIT_DIV=4 and BIT_DIV=1),
// a frame-level reference model compared every cycle, and directed frames
// checked against hand-written line patterns and latencies.
// Honours TX_PARITY_EN the same way as the design.
module tb_byte_tx_serializer;

`ifdef TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] F_A5 = 11'b10101001010;
  localparam logic [10:0] F_81 = 11'b10100000010;
  localparam logic [10:0] F_07 = 11'b11000001110;
  localparam logic [10:0] F_03 = 11'b10000000110;
`else
  localparam int NB = 10;
  localparam logic [10:0] F_A5 = 11'b01101001010;
  localparam logic [10:0] F_81 = 11'b01100000010;
  localparam logic [10:0] F_07 = 11'b01000001110;
  localparam logic [10:0] F_03 = 11'b01000000110;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] vld;
  logic [7:0] dat [2];
  logic [1:0] rdy, tx, bsy, dn;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  byte_tx_serializer #(.DATA_W(8), .BIT_DIV(4)) dut4 (
    .CLK(CLK), .RST(RST), .IN_VALID(vld[0]), .IN_DATA(dat[0]),
    .IN_READY(rdy[0]), .TX_OUT(tx[0]), .BUSY(bsy[0]), .DONE(dn[0]));

  byte_tx_serializer #(.DATA_W(8), .BIT_DIV(1)) dut1 (
    .CLK(CLK), .RST(RST), .IN_VALID(vld[1]), .IN_DATA(dat[1]),
    .IN_READY(rdy[1]), .TX_OUT(tx[1]), .BUSY(bsy[1]), .DONE(dn[1]));

  function automatic int bd_of(input int id);
    return (id == 0) ? 4 : 1;
  endfunction

  // Frame bit k of word w: start, 8 data LSB-first, [even parity], stop.
  function automatic logic fbit(input logic [7:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return w[k-1];
`ifdef TX_PARITY_EN
    if (k == 9) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a frame is NB*BIT_DIV cycles counted from the accept
  // edge; the next cycle is the DONE cycle, in which a new word may be taken.
  bit         m_busy [2];
  bit         m_done [2];
  int         m_n    [2];
  logic [7:0] m_w    [2];

  always @(posedge CLK or posedge RST) begin
    for (int i = 0; i < 2; i++) begin
      if (RST) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_n[i]    <= 0;
      end else begin
        m_done[i] <= 1'b0;
        if (m_busy[i]) begin
          if (m_n[i] + 1 == NB * bd_of(i)) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
          end
          m_n[i] <= m_n[i] + 1;
        end else if (vld[i]) begin
          m_busy[i] <= 1'b1;
          m_n[i]    <= 0;
          m_w[i]    <= dat[i];
        end
      end
    end
  end

  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("tx%0d", i), 32'(tx[i]),
          32'(m_busy[i] ? fbit(m_w[i], m_n[i] / bd_of(i)) : 1'b1));
      chk($sformatf("busy%0d", i),  32'(bsy[i]), 32'(m_busy[i]));
      chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(!m_busy[i]));
      chk($sformatf("done%0d", i),  32'(dn[i]),  32'(m_done[i]));
    end
  end

  // Send one word, sample the line on the first cycle of each bit and
  // measure accept-edge-to-DONE latency.
  task automatic send_cap(input int id, input logic [7:0] w,
                          input logic [10:0] exp_f, input string nm);
    int bd;
    int lat;
    logic [10:0] cap;
    bd  = bd_of(id);
    lat = -1;
    cap = '0;
    @(posedge CLK); #2 vld[id] = 1'b1; dat[id] = w;
    @(posedge CLK); #2 vld[id] = 1'b0; dat[id] = ~w;
    for (int n = 0; n < 200 && lat < 0; n++) begin
      @(negedge CLK);
      if (n < NB * bd && (n % bd) == 0) cap[n / bd] = tx[id];
      if (dn[id]) lat = n;
    end
    chk({nm, "_frame"}, 32'(cap), 32'(exp_f));
    chk({nm, "_latency"}, 32'(lat), 32'(NB * bd));
  endtask

  initial begin
    logic line [0:199];
    int   dcnt;
    int   L;
    RST = 1'b1;
    vld = '0;
    dat[0] = '0;
    dat[1] = '0;
    #3;
    chk("rst_tx",    32'(tx[0]),  32'h1);
    chk("rst_busy",  32'(bsy[0]), 32'h0);
    chk("rst_ready", 32'(rdy[0]), 32'h1);
    chk("rst_done",  32'(dn[0]),  32'h0);
    @(posedge CLK); @(posedge CLK); #2 RST = 1'b0;

    // Idle: the per-cycle compare covers the line staying high.
    repeat (20) @(negedge CLK);
    chk("idle_tx", 32'(tx[0]), 32'h1);

    send_cap(0, 8'hA5, F_A5, "a5_div4");

    // Back-to-back with valid held: second word taken in the DONE cycle.
    L = NB * 4;
    dcnt = 0;
    @(posedge CLK); #2 vld[0] = 1'b1; dat[0] = 8'h00;
    @(posedge CLK); #2 dat[0] = 8'hFF;
    for (int n = 0; n <= 2 * L + 1; n++) begin
      @(negedge CLK);
      line[n] = tx[0];
      if (dn[0]) dcnt++;
      if (n == L + 1) vld[0] = 1'b0;
    end
    chk("b2b_data0",   32'(line[4]),         32'h0);
    chk("b2b_stop",    32'(line[L - 1]),     32'h1);
    chk("b2b_gap",     32'(line[L]),         32'h1);
    chk("b2b_start2",  32'(line[L + 1]),     32'h0);
    chk("b2b_data2",   32'(line[L + 1 + 4]), 32'h1);
    chk("b2b_dones",   32'(dcnt),            32'd2);

    // Reset 13 cycles into a 0x3C frame.
    @(posedge CLK); #2 vld[0] = 1'b1; dat[0] = 8'h3C;
    @(posedge CLK); #2 vld[0] = 1'b0;
    repeat (13) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("midrst_tx",   32'(tx[0]),  32'h1);
    chk("midrst_busy", 32'(bsy[0]), 32'h0);
    chk("midrst_done", 32'(dn[0]),  32'h0);
    @(posedge CLK); @(posedge CLK); #2 RST = 1'b0;
    dcnt = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge CLK);
      if (dn[0]) dcnt++;
    end
    chk("midrst_nodone", 32'(dcnt), 32'd0);
    send_cap(0, 8'h81, F_81, "81_after_rst");

    send_cap(1, 8'h81, F_81, "81_div1");
    send_cap(0, 8'h07, F_07, "07_div4");
    send_cap(0, 8'h03, F_03, "03_div4");

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
